bin_bcd: RTL and testbench
==========================

BIN_BCD -- requirements
Module: bin_bcd

Interface
REQ-001 SHALL have port: clk  input  1  system clock, all state on rising edge.
REQ-002 SHALL have port: reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-003 SHALL have port: bin  input  8  unsigned binary value from the upstream 8-bit counter (q).
REQ-004 SHALL have port: in_valid  input  1  bin is valid this cycle.
REQ-005 SHALL have port: in_ready  output  1  block can accept a new value.
REQ-006 SHALL have port: out_ready  input  1  downstream consumes the result this cycle.
REQ-007 SHALL have port: out_valid  output  1  digits hold a finished conversion.
REQ-008 SHALL have ports: bcd2, bcd1, bcd0  output  4 each  hundreds, tens and units digits.

Function
REQ-009 SHALL implement the FSM states IDLE, SHIFT and DONE.
REQ-010 SHALL drive in_ready=1 only in IDLE.
REQ-011 SHALL, in IDLE with in_valid=1, capture bin, clear the 12-bit BCD accumulator, load the iteration count 8 and go to SHIFT.
REQ-012 SHALL, in each SHIFT cycle, add 3 to every accumulator digit >=5, then shift {accumulator, bin register} left by 1 and decrement the count (double-dabble).
REQ-013 SHALL leave SHIFT after the 8th iteration, register the digits into bcd2..bcd0 and enter DONE.
REQ-014 SHALL assert out_valid from the cycle after the acceptance edge plus 8 cycles; total latency from acceptance to out_valid is 9 clocks.
REQ-015 SHALL hold out_valid and the digits stable in DONE until out_ready=1, then return to IDLE on that edge.
REQ-016 SHALL ignore in_valid while in SHIFT or DONE; no input is lost because in_ready=0 there.
REQ-017 SHALL produce bcd2 in the range 0..2 and bcd1/bcd0 in the range 0..9 for every input 0..255.
REQ-018 SHALL, when out_ready and in_valid are both 1 in DONE, return to IDLE first and accept the new input on the next edge; no back-to-back bypass.
REQ-019 SHALL keep the bcd outputs at their last value outside DONE; only out_valid qualifies them.

Reset
REQ-020 SHALL, while reset=0, immediately force state IDLE, out_valid=0, digits=0, accumulator=0 and count=0, independent of clk.
REQ-021 SHALL abort an in-flight conversion on reset mid-SHIFT or in DONE without producing a result.
REQ-022 SHALL release reset cleanly with in_ready=1 on the first clock after deassertion.

Configuration
REQ-023 SHALL, with BIN_BCD_LEADZERO_EN defined, replace leading zero digits by 4'hF (blank code) at DONE: bcd2 is blanked when 0; bcd1 is blanked when both bcd2 and bcd1 are 0; bcd0 is never blanked.
REQ-024 SHALL, without BIN_BCD_LEADZERO_EN, output plain BCD digits with zeros shown.

Structure
REQ-025 SHALL place the state enum (IDLE/SHIFT/DONE), the BCD_BLANK=4'hF constant and the width constant BIN_W=8 in the shared package bin_bcd_pkg.
REQ-026 SHALL use one sub-module, bcd_add3 (combinational per-digit: +3 if >=5), instantiated three times.

Verification
REQ-027 SHALL verify: bin=8'd0 accepted -> out_valid after 9 clocks, digits 0/0/0 (blank-enabled build: F/F/0).
REQ-028 SHALL verify: bin=8'd255 -> digits 2/5/5; bin=8'd100 -> 1/0/0; bin=8'd9 -> 0/0/9 (blank build: F/F/9).
REQ-029 SHALL verify: out_ready held 0 for 20 cycles after done -> out_valid and digits stable; in_ready=0 throughout; in_valid pulses ignored.
REQ-030 SHALL verify: reset=0 asserted at SHIFT iteration 4 -> out_valid stays 0, in_ready=1 after release, and the next bin=8'd42 yields 0/4/2.
REQ-031 SHALL verify: the upstream counter is driven 0..255 with in_valid on each in_ready -> all 256 results match the reference decimal conversion.
REQ-032 SHALL verify: out_ready=1 and in_valid=1 in the same DONE cycle -> IDLE on that edge, new value accepted on the following edge.

Source files
------------

// File: rtl/bin_bcd_pkg.sv
//------------------------------------------------------------------------------
// Module   : bin_bcd_pkg
// Brief    : Shared types and constants for the 8-bit binary to BCD converter.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package bin_bcd_pkg;

    // Width of the binary input word
    localparam int BIN_W = 8;

    // Three BCD digits: hundreds, tens, units
    localparam int BCD_W = 12;

    // Code driven on a suppressed leading digit
    localparam logic [3:0] BCD_BLANK = 4'hF;

    // One shift per input bit
    localparam logic [3:0] ITER_N = 4'd8;

    // Converter control states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

endpackage

`default_nettype wire

// File: rtl/bin_bcd_add3.sv
//------------------------------------------------------------------------------
// Module   : bcd_add3
// Brief    : Double-dabble digit correction: adds 3 to a BCD digit >= 5 so
//            the following left shift carries correctly into the next digit.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module bcd_add3 (
    input  logic [3:0] digit_i,
    output logic [3:0] digit_o
);

    // Digits only ever hold 0..9 here, so the +3 result never wraps
    assign digit_o = (digit_i >= 4'd5) ? (digit_i + 4'd3) : digit_i;

endmodule

`default_nettype wire

// File: rtl/bin_bcd.sv
//------------------------------------------------------------------------------
// Module   : bin_bcd
// Brief    : Sequential 8-bit binary to 3-digit BCD converter (double-dabble),
//            one bit per clock, valid/ready handshake on both sides.
//            Optional build macro BIN_BCD_LEADZERO_EN replaces leading zero
//            digits with the blank code 4'hF.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module bin_bcd
    import bin_bcd_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic [BIN_W-1:0] bin,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [3:0]       bcd2,
    output logic [3:0]       bcd1,
    output logic [3:0]       bcd0
);

    state_e             state_q, state_d;
    logic [BIN_W-1:0]   bin_q, bin_d;
    logic [BCD_W-1:0]   acc_q, acc_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [3:0]         bcd2_q, bcd1_q, bcd0_q;
    logic [3:0]         bcd2_d, bcd1_d, bcd0_d;
    logic               load_digits;
    logic [BCD_W-1:0]   w_adj;
    logic [BCD_W-1:0]   w_acc_sh;

    // Per-digit +3 correction ahead of every shift
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_digit
            bcd_add3 u_add3 (
                .digit_i (acc_q[gi*4 +: 4]),
                .digit_o (w_adj[gi*4 +: 4])
            );
        end
    endgenerate

    // Corrected accumulator shifted left, taking the next binary MSB
    assign w_acc_sh = {w_adj[BCD_W-2:0], bin_q[BIN_W-1]};

    // Next-state logic: accept, iterate eight times, hold until consumed
    always_comb begin
        state_d     = state_q;
        bin_d       = bin_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        load_digits = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    bin_d   = bin;
                    acc_d   = '0;
                    cnt_d   = ITER_N;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                acc_d = w_acc_sh;
                // The accumulator MSB cannot be set for an 8-bit input; it is
                // rotated into the vacated LSB so the 20-bit word is a rotate.
                bin_d = {bin_q[BIN_W-2:0], w_adj[BCD_W-1]};
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d     = DONE;
                    load_digits = 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output digit selection, with optional leading-zero blanking
    always_comb begin
        bcd2_d = bcd2_q;
        bcd1_d = bcd1_q;
        bcd0_d = bcd0_q;
        if (load_digits) begin
            bcd2_d = w_acc_sh[11:8];
            bcd1_d = w_acc_sh[7:4];
            bcd0_d = w_acc_sh[3:0];
`ifdef BIN_BCD_LEADZERO_EN
            if (w_acc_sh[11:8] == 4'd0) begin
                bcd2_d = BCD_BLANK;
                if (w_acc_sh[7:4] == 4'd0) begin
                    bcd1_d = BCD_BLANK;
                end
            end
`endif
        end
    end

    // State, datapath and result registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            bin_q   <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            bcd2_q  <= '0;
            bcd1_q  <= '0;
            bcd0_q  <= '0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            bcd2_q  <= bcd2_d;
            bcd1_q  <= bcd1_d;
            bcd0_q  <= bcd0_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign bcd2      = bcd2_q;
    assign bcd1      = bcd1_q;
    assign bcd0      = bcd0_q;

endmodule

`default_nettype wire

// File: tb/tb_bin_bcd.sv
//------------------------------------------------------------------------------
// Module   : tb_bin_bcd
// Brief    : Directed self-checking bench for bin_bcd.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_bin_bcd;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] bin;
    logic       in_valid;
    logic       in_ready;
    logic       out_ready;
    logic       out_valid;
    logic [3:0] bcd2, bcd1, bcd0;

    int n_cmp = 0;
    int n_bad = 0;

    bin_bcd dut (
        .clk       (clk),
        .reset     (reset),
        .bin       (bin),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .bcd2      (bcd2),
        .bcd1      (bcd1),
        .bcd0      (bcd0)
    );

    always #5 clk = ~clk;

    // Decimal reference: hundreds/tens/units, blanking leading zeros if enabled
    function automatic logic [11:0] ref_bcd(input int v);
        logic [3:0] h, t, u;
        h = 4'(v / 100);
        t = 4'((v / 10) % 10);
        u = 4'(v % 10);
`ifdef BIN_BCD_LEADZERO_EN
        if (h == 4'd0) begin
            h = 4'hF;
            if (t == 4'd0) t = 4'hF;
        end
`endif
        return {h, t, u};
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present v until accepted; returns after the acceptance edge
    task automatic accept(input logic [7:0] v);
        int k;
        k = 0;
        while (!in_ready && k < 40) begin
            step();
            k++;
        end
        if (!in_ready) check("accept_timeout", 16'd0, 16'd1);
        bin      = v;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    // Count edges after acceptance until out_valid, bounded
    task automatic wait_done(output int lat);
        lat = 0;
        while (!out_valid && lat < 40) begin
            step();
            lat++;
        end
    endtask

    // Full transaction: accept, check latency and digits, consume
    task automatic convert(input logic [7:0] v, input string tag);
        int lat;
        accept(v);
        wait_done(lat);
        check({tag, "_latency"}, 16'(lat), 16'd8);
        check({tag, "_digits"}, {4'd0, bcd2, bcd1, bcd0}, {4'd0, ref_bcd(int'(v))});
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check({tag, "_consumed"}, {15'd0, out_valid}, 16'd0);
    endtask

    initial begin
        int         lat;
        int         saw;
        logic [11:0] held;

        reset     = 1'b0;
        bin       = 8'd0;
        in_valid  = 1'b0;
        out_ready = 1'b0;

        // Reset state
        #2;
        check("rst_out_valid", {15'd0, out_valid}, 16'd0);
        check("rst_in_ready", {15'd0, in_ready}, 16'd1);
        check("rst_digits", {4'd0, bcd2, bcd1, bcd0}, 16'd0);
        step();
        step();
        reset = 1'b1;
        step();
        check("rel_in_ready", {15'd0, in_ready}, 16'd1);

        // Basic conversions, including extreme values
        convert(8'd0,   "v0");
        convert(8'd255, "v255");
        convert(8'd100, "v100");
        convert(8'd9,   "v9");

        // in_ready drops during SHIFT
        accept(8'd123);
        check("shift_in_ready", {15'd0, in_ready}, 16'd0);
        wait_done(lat);
        check("hold_latency", 16'(lat), 16'd8);

        // Hold in DONE for 20 cycles with in_valid pulses
        held = ref_bcd(123);
        for (int i = 0; i < 20; i++) begin
            in_valid = i[0];
            bin      = 8'(i * 7);
            step();
            check("hold_out_valid", {15'd0, out_valid}, 16'd1);
            check("hold_digits", {4'd0, bcd2, bcd1, bcd0}, {4'd0, held});
            check("hold_in_ready", {15'd0, in_ready}, 16'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("hold_release_valid", {15'd0, out_valid}, 16'd0);
        check("hold_release_ready", {15'd0, in_ready}, 16'd1);

        // Reset during the fourth shift iteration
        accept(8'd200);
        step();
        step();
        step();
        reset = 1'b0;
        #1;
        check("abort_out_valid", {15'd0, out_valid}, 16'd0);
        check("abort_in_ready", {15'd0, in_ready}, 16'd1);
        check("abort_digits", {4'd0, bcd2, bcd1, bcd0}, 16'd0);
        step();
        step();
        reset = 1'b1;
        step();
        check("abort_rel_ready", {15'd0, in_ready}, 16'd1);
        saw = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (out_valid) saw++;
        end
        check("abort_no_result", 16'(saw), 16'd0);
        convert(8'd42, "v42");

        // Consume and new request in the same DONE cycle
        accept(8'd57);
        wait_done(lat);
        check("b2b_first_digits", {4'd0, bcd2, bcd1, bcd0}, {4'd0, ref_bcd(57)});
        out_ready = 1'b1;
        in_valid  = 1'b1;
        bin       = 8'd77;
        step();
        out_ready = 1'b0;
        check("b2b_idle_valid", {15'd0, out_valid}, 16'd0);
        check("b2b_idle_ready", {15'd0, in_ready}, 16'd1);
        step();
        in_valid = 1'b0;
        check("b2b_accepted", {15'd0, in_ready}, 16'd0);
        wait_done(lat);
        check("b2b_latency", 16'(lat), 16'd8);
        check("b2b_digits", {4'd0, bcd2, bcd1, bcd0}, {4'd0, ref_bcd(77)});
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;

        // Upstream counter sweep over every input value
        for (int v = 0; v < 256; v++) begin
            convert(8'(v), "sweep");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
